mem_arbiter: RTL
================

# mem_arbiter

Sequencer directly upstream of the MMU. It merges the instruction-fetch port and the data-access port of the pipeline onto the MMU's single read/write request interface. It holds each access steady for a fixed number of cycles so the SRAM/UART phase logic can complete. It returns read data and a one-cycle ready pulse to the requester, and raises a pipeline stall request while any access is outstanding.

## Interface
Parameters:
- WAIT_CYCLES, 1: extra cycles an MMU request is held beyond the first; legal range 0–15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  32  fetched word; valid only when if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_rd  in  1  data read request; held until mem_ready.
- mem_wr  in  1  data write request; held until mem_ready.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  32  write data.
- mem_byte  in  1  byte-mode access.
- mem_rdata  out  32  load result; valid only when mem_ready.
- mem_ready  out  1  one-cycle completion pulse for data.
- stall_req  out  1  pipeline stall request.
- mmu_read  out  1  to MMU if_read.
- mmu_write  out  1  to MMU if_write.
- mmu_addr  out  32  to MMU addr (zero-extended when ADDR_W<32).
- mmu_wdata  out  32  to MMU input_data.
- mmu_bytemode  out  1  to MMU bytemode.
- mmu_rdata  in  32  from MMU output_data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If mem_rd|mem_wr, latch src=DATA, the address, wdata, byte flag and direction, then go to ACCESS.
  - Else if if_req, latch src=FETCH, if_addr, word mode and read, then go to ACCESS.
  - Data always has priority over fetch.
- ACCESS:
  - mmu_read or mmu_write is driven from the latched direction. Address, wdata and bytemode come from the latch and stay constant.
  - A 4-bit counter counts 0..WAIT_CYCLES. On the cycle where count==WAIT_CYCLES, mmu_rdata is captured into the response register and the FSM goes to RESP.
- RESP:
  - Exactly one of if_ready or mem_ready is 1, chosen by src. if_rdata and mem_rdata both present the response register. The FSM returns to IDLE.
  - A write pulses mem_ready; mem_rdata is don't-care for writes.
- mem_rd and mem_wr both high: treated as a write.
- stall_req = (if_req & ~if_ready) | ((mem_rd|mem_wr) & ~mem_ready), combinational.
- A fetch left waiting behind a data access is served on the IDLE cycle immediately after the data RESP, provided if_req is still high.
- Requests that drop before their ready pulse are an illegal requester action. The started access still completes and its ready pulse is issued.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - mmu_read=0, mmu_write=0, mmu_addr=0, mmu_wdata=0, mmu_bytemode=0.
  - if_ready=0, mem_ready=0, response register 0.
- Uncached access latency: request sampled in IDLE at edge N; ACCESS occupies WAIT_CYCLES+1 cycles; ready is high in cycle N+WAIT_CYCLES+2. With the default, ready arrives 3 cycles after the request is sampled.
- Back-to-back: the next request is sampled in the IDLE cycle after RESP. Sustained throughput is one access per WAIT_CYCLES+3 cycles.
- mmu_read and mmu_write are never high together, and are never high outside ACCESS.
- Reset asserted mid-access:
  - All MMU strobes drop immediately, asynchronously.
  - The FSM goes to IDLE, and no ready pulse is issued for the aborted access.

## Configuration
- FETCH_BUFFER_EN defined: adds a one-entry fetch buffer (valid, address tag, data).
  - Fill: the buffer is loaded on every completed fetch.
  - Invalidate: the buffer is cleared on reset and on any accepted data write.
  - Hit: in IDLE with no data request, if_req set, valid set and tag==if_addr, the FSM skips ACCESS. It goes to RESP with the buffered word, so if_ready arrives 1 cycle after the request is sampled, with no MMU strobe.
- FETCH_BUFFER_EN undefined: no buffer; every fetch goes through ACCESS.

## Test plan
- Single fetch, WAIT_CYCLES=1, if_addr=0x8000_0010, mmu_rdata=0x2408_0005 -> mmu_read high for exactly 2 cycles; if_ready pulses in cycle 3 after the request is sampled; if_rdata=0x2408_0005.
- if_req and mem_wr (addr 0x8040_0000, wdata 0xDEAD_BEEF) raised in the same cycle -> mmu_write is issued first with those values; mem_ready pulses; the fetch then starts on the next IDLE cycle; stall_req stays high until if_ready.
- Byte load, mem_rd with mem_byte=1, addr 0xBFD0_03F8 -> mmu_bytemode=1 throughout ACCESS; mem_ready pulses with mem_rdata equal to captured mmu_rdata.
- rst asserted in the middle of the ACCESS cycle of a write -> mmu_write drops in the same cycle; no mem_ready; after release the FSM is in IDLE and all outputs are at reset values.
- With FETCH_BUFFER_EN defined: two fetches of 0x8000_0000 -> the second has a 1-cycle if_ready and no MMU strobe. An intervening mem_wr forces the next fetch of 0x8000_0000 back to full latency.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and MMU-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_byte;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              stall_req;
  logic              mmu_read;
  logic              mmu_write;
  logic [31:0]       mmu_addr;
  logic [31:0]       mmu_wdata;
  logic              mmu_bytemode;
  logic [31:0]       mmu_rdata;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte, mmu_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
           mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte, mmu_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
           mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data merge onto the MMU port with fixed hold time
// Optional one-entry fetch buffer enabled by defining FETCH_BUFFER_EN.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        src_data;
  logic        lat_wr;
  logic        lat_byte;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] resp_data;
  logic        take_data;
  logic        take_fetch;
  logic        done;

`ifdef FETCH_BUFFER_EN
  logic        fb_valid;
  logic [31:0] fb_tag;
  logic [31:0] fb_data;
  logic        fb_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    take_data      = 1'b0;
    take_fetch     = 1'b0;
    done           = 1'b0;
    bus.mmu_read   = 1'b0;
    bus.mmu_write  = 1'b0;
    bus.if_ready   = 1'b0;
    bus.mem_ready  = 1'b0;
`ifdef FETCH_BUFFER_EN
    fb_hit         = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.mem_rd || bus.mem_wr) begin
          take_data  = 1'b1;
          state_next = ACCESS;
        end else if (bus.if_req) begin
`ifdef FETCH_BUFFER_EN
          if (fb_valid && fb_tag == 32'(bus.if_addr)) begin
            fb_hit     = 1'b1;
            state_next = RESP;
          end else begin
            take_fetch = 1'b1;
            state_next = ACCESS;
          end
`else
          take_fetch = 1'b1;
          state_next = ACCESS;
`endif
        end
      end
      ACCESS: begin
        bus.mmu_read  = ~lat_wr;
        bus.mmu_write = lat_wr;
        if (count == 4'(WAIT_CYCLES)) begin
          done       = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        bus.if_ready  = ~src_data;
        bus.mem_ready = src_data;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous rd+wr is latched as a write because lat_wr takes mem_wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 4'd0;
      src_data  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      resp_data <= 32'd0;
    end else begin
      if (take_data) begin
        src_data  <= 1'b1;
        lat_wr    <= bus.mem_wr;
        lat_addr  <= 32'(bus.mem_addr);
        lat_wdata <= bus.mem_wdata;
        lat_byte  <= bus.mem_byte;
        count     <= 4'd0;
      end else if (take_fetch) begin
        src_data  <= 1'b0;
        lat_wr    <= 1'b0;
        lat_addr  <= 32'(bus.if_addr);
        lat_byte  <= 1'b0;
        count     <= 4'd0;
      end
      if (state == ACCESS) count <= count + 4'd1;
      if (done) resp_data <= bus.mmu_rdata;
`ifdef FETCH_BUFFER_EN
      if (fb_hit) begin
        src_data  <= 1'b0;
        resp_data <= fb_data;
      end
`endif
    end
  end

`ifdef FETCH_BUFFER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid <= 1'b0;
      fb_tag   <= 32'd0;
      fb_data  <= 32'd0;
    end else begin
      if (done && !src_data) begin
        fb_valid <= 1'b1;
        fb_tag   <= lat_addr;
        fb_data  <= bus.mmu_rdata;
      end
      if (take_data && bus.mem_wr) fb_valid <= 1'b0;
    end
  end
`endif

  assign bus.mmu_addr     = lat_addr;
  assign bus.mmu_wdata    = lat_wdata;
  assign bus.mmu_bytemode = lat_byte;
  assign bus.if_rdata     = resp_data;
  assign bus.mem_rdata    = resp_data;
  assign bus.stall_req    = (bus.if_req & ~bus.if_ready) |
                            ((bus.mem_rd | bus.mem_wr) & ~bus.mem_ready);

endmodule
